// File: rtl/led_scan_display.sv
// Time-multiplexed driver for a common-anode bank of 7-segment digits with double-buffered display data.
// Optional leading-zero suppression is enabled by defining LED_SCAN_LZ_SUPPRESS_EN.
module led_scan_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_load,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig_sel,
    output logic                    o_frame_done,
    output logic                    o_pending
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;

    logic [3:0]              cur_val;
    logic                    cur_dp;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   sel_n;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    assign wrap = (presc == PRESC_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Active data only moves at the frame wrap, so every frame comes from one snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            o_pending  <= 1'b0;
        end else if (wrap) begin
            if (i_load) begin
                act_data  <= i_data;
                act_dp    <= i_dp;
                act_blank <= i_blank;
            end else if (o_pending) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            o_pending <= 1'b0;
        end else if (i_load) begin
            pend_data  <= i_data;
            pend_dp    <= i_dp;
            pend_blank <= i_blank;
            o_pending  <= 1'b1;
        end
    end

`ifdef LED_SCAN_LZ_SUPPRESS_EN
    // Walk down from the most significant digit; digit 0 always stays visible.
    always_comb begin
        logic leading;
        lz_mask = '0;
        leading = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (leading && (act_data[4*k +: 4] == 4'h0) && !act_dp[k]) begin
                lz_mask[k] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_val  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        sel_n    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx) begin
                cur_val  = act_data[4*k +: 4];
                cur_dp   = act_dp[k];
                cur_dark = act_blank[k] | lz_mask[k];
                sel_n[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_seg        <= 8'hFF;
            o_dig_sel    <= '1;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= wrap;
            if (presc < BLANK_END) begin
                o_seg     <= 8'hFF;
                o_dig_sel <= '1;
            end else begin
                o_dig_sel <= sel_n;
                o_seg     <= cur_dark ? 8'hFF : ~{cur_dp, hex_to_seg(cur_val)};
            end
        end
    end

endmodule

// File: tb/tb_led_scan_display.sv
// Scoreboard bench for led_scan_display (4 digits, 4-cycle slots, 1 blanking cycle).
// Expected digit patterns follow LED_SCAN_LZ_SUPPRESS_EN when it is defined.
module tb_led_scan_display;

    localparam int ND = 4;

`ifdef LED_SCAN_LZ_SUPPRESS_EN
    localparam logic [7:0] ZH = 8'hFF;
`else
    localparam logic [7:0] ZH = 8'hC0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*ND-1:0] i_data;
    logic [ND-1:0]   i_dp;
    logic [ND-1:0]   i_blank;
    logic            i_load;
    logic [7:0]      o_seg;
    logic [ND-1:0]   o_dig_sel;
    logic            o_frame_done;
    logic            o_pending;

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   r0;
    int   r2;

    led_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_dp         (i_dp),
        .i_blank      (i_blank),
        .i_load       (i_load),
        .o_seg        (o_seg),
        .o_dig_sel    (o_dig_sel),
        .o_frame_done (o_frame_done),
        .o_pending    (o_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic [7:0] seg, input logic [3:0] sel,
                            input logic fd, input logic pend);
        exp_t e;
        e.cyc  = c;
        e.seg  = seg;
        e.sel  = sel;
        e.fd   = fd;
        e.pend = pend;
        exp_q.push_back(e);
    endtask

    // segs = {digit3, digit2, digit1, digit0}; first cycle of each slot is blanked.
    task automatic expect_frame(input int start, input logic [31:0] segs,
                                input int pend_from, input int ncyc);
        logic [3:0] one;
        for (int j = 0; j < ncyc; j++) begin
            int s;
            s   = j / 4;
            one = 4'b0001 << s;
            if (j % 4 == 0)
                push_exp(start + j, 8'hFF, 4'hF, j == 15, (j >= pend_from) && (j < 15));
            else
                push_exp(start + j, segs[8*s +: 8], ~one, j == 15, (j >= pend_from) && (j < 15));
        end
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        i_data  = d;
        i_dp    = dp;
        i_blank = bl;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    task automatic check_output();
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_compared++;
            if (e.cyc != cyc) begin
                n_mismatched++;
                $display("[TB] FAIL missed_cycle%0d: monitor reached cycle %0d, required cycle %0d", e.cyc, cyc, e.cyc);
            end else if ({o_seg, o_dig_sel, o_frame_done, o_pending} !== {e.seg, e.sel, e.fd, e.pend}) begin
                n_mismatched++;
                $display("[TB] FAIL cycle%0d: got seg=%h sel=%h fd=%b pend=%b, required seg=%h sel=%h fd=%b pend=%b",
                         cyc, o_seg, o_dig_sel, o_frame_done, o_pending, e.seg, e.sel, e.fd, e.pend);
            end
        end
    endtask

    always @(negedge clk) check_output();

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        i_load  = 1'b0;
        i_data  = '0;
        i_dp    = '0;
        i_blank = '0;
        for (int c = 1; c <= 3; c++) push_exp(c, 8'hFF, 4'hF, 1'b0, 1'b0);
        wait_cycle(3);
        rst_n = 1'b1;
        r0 = cyc;

        // Power-up: dark frames, then 1234 with dp on digit 2 loaded mid-frame.
        expect_frame(r0 + 1,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16, 16);
        expect_frame(r0 + 17, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4, 16);
        wait_cycle(r0 + 20);
        apply_stimulus(16'h1234, 4'b0100, 4'b0000);

        // Two loads in one frame: only the last is committed.
        wait_cycle(r0 + 32);
        expect_frame(r0 + 33, {8'hF9, 8'h24, 8'hB0, 8'h99}, 2, 16);
        expect_frame(r0 + 49, {8'h92, 8'h92, 8'h92, 8'h92}, 16, 16);
        wait_cycle(r0 + 34);
        apply_stimulus(16'hAAAA, 4'b0000, 4'b0000);
        wait_cycle(r0 + 40);
        apply_stimulus(16'h5555, 4'b0000, 4'b0000);

        // Load on the wrap cycle bypasses pending.
        wait_cycle(r0 + 48);
        expect_frame(r0 + 65, {ZH, ZH, 8'h8E, 8'hC0}, 16, 16);
        wait_cycle(r0 + 63);
        apply_stimulus(16'h00F0, 4'b0000, 4'b0000);

        // Per-digit blank on digit 0 plus zeros in the upper digits.
        wait_cycle(r0 + 64);
        expect_frame(r0 + 81, {ZH, ZH, 8'h8E, 8'hC0}, 2, 16);
        wait_cycle(r0 + 82);
        apply_stimulus(16'h0070, 4'b0000, 4'b0001);

        // Reset during slot 2 with a load pending: pending is lost, display stays dark.
        wait_cycle(r0 + 96);
        r2 = r0 + 108;
        expect_frame(r0 + 97, {ZH, ZH, 8'hF8, 8'hFF}, 2, 10);
        push_exp(r0 + 107, 8'hFF, 4'hF, 1'b0, 1'b0);
        push_exp(r0 + 108, 8'hFF, 4'hF, 1'b0, 1'b0);
        expect_frame(r2 + 1,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16, 16);
        expect_frame(r2 + 17, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16, 16);
        wait_cycle(r0 + 98);
        apply_stimulus(16'h1234, 4'b0000, 4'b0000);
        wait_cycle(r0 + 106);
        rst_n = 1'b0;
        wait_cycle(r2);
        rst_n = 1'b1;

        wait_cycle(r2 + 34);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL leftover_expectations: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
